// File: rtl/load_store_unit.sv
// load_store_unit: data-memory responder for the single-cycle core.
// Accepts one load/store per request, runs it on a word-addressed req/ack bus,
// formats store lanes, extends load data, and flags illegal or misaligned
// accesses without touching the bus.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  mem_write_enable_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           store_data_i,
  output logic                  stall_o,
  output logic                  load_valid_o,
  output logic [31:0]           load_data_o,
  output logic                  fault_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-3:0] bus_addr_o,
  output logic [31:0]           bus_wdata_o,
  output logic [3:0]            bus_wstrb_o,
  input  logic                  bus_ack_i,
  input  logic [31:0]           bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    accept_s;
  logic                    legal_s;
  logic                    stall_s;
  logic                    we_r;
  logic [2:0]              funct3_r;
  logic [1:0]              offset_r;
  logic                    load_valid_r;
  logic                    fault_r;
  logic [31:0]             load_data_r;
  logic                    bus_req_r;
  logic                    bus_we_r;
  logic [ADDR_WIDTH-3:0]   bus_addr_r;
  logic [31:0]             bus_wdata_r;
  logic [3:0]              bus_wstrb_r;

  // Byte/halfword accesses must be naturally aligned; stores have no unsigned forms.
  function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = (off[0] == 1'b0);
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & (off[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Replicate store data across all lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] format_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{rs2[7:0]}};
      2'b01:   w = {2{rs2[15:0]}};
      default: w = rs2;
    endcase
    return w;
  endfunction

  // Reads never drive strobes.
  function automatic logic [3:0] format_wstrb(input logic we, input logic [2:0] f3,
                                              input logic [1:0] off);
    logic [3:0] s;
    if (!we) begin
      s = 4'b0000;
    end else begin
      case (f3[1:0])
        2'b00:   s = 4'b0001 << off;
        2'b01:   s = 4'b0011 << off;
        default: s = 4'b1111;
      endcase
    end
    return s;
  endfunction

  // Pick the addressed byte/halfword and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [15:0] half;
    logic [31:0] r;
    shifted = rdata >> {off, 3'b000};
    half    = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  r = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  r = {24'h000000, shifted[7:0]};
      3'b001:  r = {{16{half[15]}}, half};
      3'b101:  r = {16'h0000, half};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Next-state decode, request acceptance and the combinational stall.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    stall_s      = 1'b0;
    legal_s      = access_legal(mem_write_enable_i, funct3_i, addr_i[1:0]);
    case (state_r)
      IDLE: begin
        if (req_valid_i) begin
          accept_s     = 1'b1;
          stall_s      = 1'b1;
          state_next_s = legal_s ? BUS : DONE;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUS: begin
        stall_s = 1'b1;
        if (bus_ack_i) begin
          state_next_s = DONE;
        end else begin
          state_next_s = BUS;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register plus registered bus/result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      offset_r     <= 2'b00;
      load_valid_r <= 1'b0;
      fault_r      <= 1'b0;
      load_data_r  <= 32'h0000_0000;
      bus_req_r    <= 1'b0;
      bus_we_r     <= 1'b0;
      bus_addr_r   <= '0;
      bus_wdata_r  <= 32'h0000_0000;
      bus_wstrb_r  <= 4'b0000;
    end else begin
      state_r      <= state_next_s;
      load_valid_r <= 1'b0;
      fault_r      <= 1'b0;
      if (accept_s) begin
        we_r     <= mem_write_enable_i;
        funct3_r <= funct3_i;
        offset_r <= addr_i[1:0];
        if (legal_s) begin
          bus_req_r   <= 1'b1;
          bus_we_r    <= mem_write_enable_i;
          bus_addr_r  <= addr_i[ADDR_WIDTH-1:2];
          bus_wdata_r <= format_wdata(funct3_i, store_data_i);
          bus_wstrb_r <= format_wstrb(mem_write_enable_i, funct3_i, addr_i[1:0]);
        end else begin
          fault_r <= 1'b1;
        end
      end else if (state_r == BUS && bus_ack_i) begin
        bus_req_r   <= 1'b0;
        bus_we_r    <= 1'b0;
        bus_wstrb_r <= 4'b0000;
        if (!we_r) begin
          load_valid_r <= 1'b1;
          load_data_r  <= extract_load(funct3_r, offset_r, bus_rdata_i);
        end
      end
    end
  end

  assign stall_o      = stall_s;
  assign load_valid_o = load_valid_r;
  assign load_data_o  = load_data_r;
  assign fault_o      = fault_r;
  assign bus_req_o    = bus_req_r;
  assign bus_we_o     = bus_we_r;
  assign bus_addr_o   = bus_addr_r;
  assign bus_wdata_o  = bus_wdata_r;
  assign bus_wstrb_o  = bus_wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model driving
// per-cycle expectations, checked by one compare process on the falling edge.
module tb_load_store_unit;

  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          mem_write_enable_i;
  logic [2:0]    funct3_i;
  logic [AW-1:0] addr_i;
  logic [31:0]   store_data_i;
  logic          stall_o;
  logic          load_valid_o;
  logic [31:0]   load_data_o;
  logic          fault_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [AW-3:0] bus_addr_o;
  logic [31:0]   bus_wdata_o;
  logic [3:0]    bus_wstrb_o;
  logic          bus_ack_i;
  logic [31:0]   bus_rdata_i;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i),
    .mem_write_enable_i(mem_write_enable_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .stall_o(stall_o), .load_valid_o(load_valid_o),
    .load_data_o(load_data_o), .fault_o(fault_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // expectations for the current cycle
  logic          chk_en = 1'b0;
  logic          exp_stall, exp_req, exp_lv, exp_fault, exp_we;
  logic [31:0]   exp_ld;
  logic [AW-3:0] exp_addr;
  logic [31:0]   exp_wdata;
  logic [3:0]    exp_wstrb;
  logic [31:0]   seen_wdata = 32'h0;
  logic [3:0]    seen_wstrb = 4'h0;
  logic          seen_we    = 1'b0;
  logic [AW-3:0] seen_addr  = '0;
  int            lv_pulses  = 0;
  int            req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b0;
    if (we && f3[2]) return 1'b0;
    sz = m_size(f3);
    return (a & (sz - 1)) == 0;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (m_size(f3))
      1:       return {24'h0, rs2[7:0]} * 32'h0101_0101;
      2:       return {16'h0, rs2[15:0]} * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input bit we, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] m;
    if (!we) return 4'h0;
    m = ((32'd1 << m_size(f3)) - 32'd1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int bits, sh;
    logic [31:0] mask, v;
    bits = 8 * m_size(f3);
    if (bits == 32) return rd;
    sh   = (bits == 8) ? 8 * a[1:0] : 8 * (a[1:0] & 2'b10);
    mask = (32'd1 << bits) - 32'd1;
    v    = (rd >> sh) & mask;
    if (!f3[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("stall", {31'h0, stall_o}, {31'h0, exp_stall});
      chk("bus_req", {31'h0, bus_req_o}, {31'h0, exp_req});
      chk("load_valid", {31'h0, load_valid_o}, {31'h0, exp_lv});
      chk("fault", {31'h0, fault_o}, {31'h0, exp_fault});
      chk("load_data", load_data_o, exp_ld);
      if (exp_req) begin
        chk("bus_we", {31'h0, bus_we_o}, {31'h0, exp_we});
        chk("bus_addr", {2'b00, bus_addr_o}, {2'b00, exp_addr});
        chk("bus_wdata", bus_wdata_o, exp_wdata);
        chk("bus_wstrb", {28'h0, bus_wstrb_o}, {28'h0, exp_wstrb});
      end
      if (bus_req_o === 1'b1) begin
        seen_wdata = bus_wdata_o;
        seen_wstrb = bus_wstrb_o;
        seen_we    = bus_we_o;
        seen_addr  = bus_addr_o;
        req_cycles++;
      end
      if (load_valid_o === 1'b1) lv_pulses++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_junk();
    req_valid_i        = 1'($urandom_range(0, 1));
    mem_write_enable_i = 1'($urandom_range(0, 1));
    funct3_i           = 3'($urandom_range(0, 7));
    addr_i             = $urandom;
    store_data_i       = $urandom;
  endtask

  task automatic go_idle();
    req_valid_i = 1'b0;
    bus_ack_i   = 1'b0;
    exp_stall   = 1'b0;
    exp_req     = 1'b0;
    exp_lv      = 1'b0;
    exp_fault   = 1'b0;
  endtask

  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input logic [31:0] rd, input int waits);
    // accept cycle
    req_valid_i        = 1'b1;
    mem_write_enable_i = we;
    funct3_i           = f3;
    addr_i             = a;
    store_data_i       = rs2;
    bus_ack_i          = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_lv = 1'b0; exp_fault = 1'b0;
    next_cycle();
    if (!m_legal(we, f3, a)) begin
      drive_junk();
      exp_stall = 1'b0; exp_fault = 1'b1;
      next_cycle();
    end else begin
      exp_req   = 1'b1; exp_stall = 1'b1;
      exp_we    = we;
      exp_addr  = a[31:2];
      exp_wdata = m_wdata(f3, rs2);
      exp_wstrb = m_wstrb(we, f3, a);
      for (int i = 0; i <= waits; i++) begin
        drive_junk();
        bus_ack_i   = (i == waits);
        bus_rdata_i = (i == waits) ? rd : $urandom;
        next_cycle();
      end
      drive_junk();
      bus_ack_i = 1'b0;
      exp_req = 1'b0; exp_stall = 1'b0; exp_lv = !we;
      if (!we) exp_ld = m_load(f3, a, rd);
      next_cycle();
    end
    go_idle();
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; mem_write_enable_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; store_data_i = 32'h0; bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    exp_ld = 32'h0; exp_we = 1'b0; exp_addr = '0; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    go_idle();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    // reset values
    chk("rst_req", {31'h0, bus_req_o}, 32'h0);
    chk("rst_we", {31'h0, bus_we_o}, 32'h0);
    chk("rst_wstrb", {28'h0, bus_wstrb_o}, 32'h0);
    chk("rst_addr", {2'b00, bus_addr_o}, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    chk("rst_ld", load_data_o, 32'h0);
    chk("rst_lv_fault", {30'h0, load_valid_o, fault_o}, 32'h0);
    chk_en = 1'b1;
    next_cycle();

    // directed: LW 0x100, ack one cycle after request
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    chk("lw_data_lit", load_data_o, 32'hDEADBEEF);
    chk("lw_addr_lit", {2'b00, seen_addr}, 32'h40);
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    chk("lb_lit", load_data_o, 32'hFFFFFF80);
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0);
    chk("lbu_lit", load_data_o, 32'h00000080);
    do_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001AAAA, 2);
    chk("lh_lit", load_data_o, 32'hFFFF8001);
    do_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001AAAA, 0);
    chk("lhu_lit", load_data_o, 32'h00008001);
    lv_pulses = 0;
    do_access(1'b1, 3'b000, 32'h201, 32'h123456AB, 32'h0, 0);
    chk("sb_wdata_lit", seen_wdata, 32'hABABABAB);
    chk("sb_wstrb_lit", {28'h0, seen_wstrb}, 32'h2);
    chk("sb_we_lit", {31'h0, seen_we}, 32'h1);
    chk("sb_no_lv", lv_pulses, 0);
    do_access(1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 1);
    chk("sh_wdata_lit", seen_wdata, 32'hBEEFBEEF);
    chk("sh_wstrb_lit", {28'h0, seen_wstrb}, 32'hC);
    chk("sh_ld_held", load_data_o, 32'h00008001);
    req_cycles = 0;
    do_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    do_access(1'b1, 3'b011, 32'h200, 32'h0, 32'h0, 0);
    chk("fault_no_req", req_cycles, 0);

    // reset during a 5-cycle wait, then a late ack in IDLE
    lv_pulses = 0;
    req_valid_i = 1'b1; mem_write_enable_i = 1'b0; funct3_i = 3'b010;
    addr_i = 32'h300; bus_ack_i = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0;
    next_cycle();
    req_valid_i = 1'b0;
    exp_req = 1'b1; exp_we = 1'b0; exp_addr = 30'h0C0; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    exp_wdata = bus_wdata_o;  // don't-care for reads; only lanes/strobes/addr matter here
    repeat (2) next_cycle();
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_ld = 32'h0;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    repeat (3) next_cycle();
    go_idle();
    next_cycle();
    chk("late_ack_no_lv", lv_pulses, 0);

    // randomized transactions
    for (int n = 0; n < 200; n++) begin
      logic [2:0] f3;
      bit we;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'(m_size(f3) == 4 ? 0 : a[1:0] & ~(m_size(f3) - 1));
      do_access(we, f3, a, $urandom, $urandom, $urandom_range(0, 3));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        bus_ack_i = 1'($urandom_range(0, 1));
        bus_rdata_i = $urandom;
        next_cycle();
      end
      go_idle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory responder for the single-cycle RISC-V core. It executes the loads and stores that the instruction decoder requests, and drives a word-addressed request/acknowledge data bus. It generates byte and halfword write strobes, and sign- or zero-extends load data. It stalls the core until the bus access completes and flags misaligned or illegal accesses without touching the bus.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width; bus address is ADDR_WIDTH-2 bits (word index).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  decoded instruction is a load or store this cycle.
- mem_write_enable_i  input  1  1 = store, 0 = load (from control decoder).
- funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  input  ADDR_WIDTH  byte address (ALU result).
- store_data_i  input  32  rs2 value.
- stall_o  output  1  hold PC and pipeline inputs.
- load_valid_o  output  1  one-cycle pulse; load_data_o valid; core writes rd.
- load_data_o  output  32  extended load result.
- fault_o  output  1  one-cycle pulse; misaligned or illegal funct3; no rd write.
- bus_req_o  output  1  bus request, held until ack.
- bus_we_o  output  1  bus write.
- bus_addr_o  output  ADDR_WIDTH-2  word address = addr_i[ADDR_WIDTH-1:2].
- bus_wdata_o  output  32  replicated store data.
- bus_wstrb_o  output  4  byte-lane write strobes; 0000 on reads.
- bus_ack_i  input  1  access complete; bus_rdata_i valid this cycle for reads.
- bus_rdata_i  input  32  read word.

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE with req_valid_i=1:
  - Latch we, funct3, addr[1:0], word address, and the formatted write data/strobes.
  - If the access is legal, go to BUS. Otherwise set a fault flag and go to DONE.
- Legality:
  - Loads accept funct3 in {000,001,010,100,101}.
  - Stores accept funct3 in {000,001,010}.
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=00.
- BUS: bus_req_o=1, with address, we, wdata and wstrb taken from the latched values.
  - On bus_ack_i=1, a read captures bus_rdata_i, then the FSM goes to DONE.
  - With no ack, stay in BUS indefinitely.
- DONE:
  - Load (no fault): load_valid_o=1.
  - Fault: fault_o=1.
  - Store: neither pulse.
  - Always go to IDLE next. req_valid_i is ignored in DONE; it is the retiring instruction.
- Store formatting:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 0011 << addr[1:0].
  - SW: wdata = rs2, wstrb = 1111.
- Load extraction:
  - Select the byte at addr[1:0] or the halfword at addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
- stall_o is combinational:
  - 1 when (IDLE and req_valid_i), or in BUS.
  - 0 in DONE and in IDLE without a request.

## Timing
- Reset: FSM to IDLE. stall_o, load_valid_o, fault_o, bus_req_o, bus_we_o = 0. bus_wstrb_o = 0000. load_data_o, bus_addr_o, bus_wdata_o = 0.
- Accept cycle T: stall_o=1. bus_req_o=1 from T+1.
- Zero-wait bus (ack at T+1): load_valid_o=1 at T+2, stall_o=0 at T+2, back in IDLE at T+3.
- Each wait state adds one cycle. Minimum 3 cycles per memory instruction.
- Fault: stall_o=1 at T, fault_o=1 at T+1, bus_req_o never asserted.
- load_data_o holds its value after the pulse until the next load completes.
- Reset in BUS: bus_req_o=0 on the next edge. An ack arriving later in IDLE is ignored.
- Outputs toward the bus are registered. Only stall_o is combinational from req_valid_i.

## Test plan
- LW at 0x100, bus_rdata_i=0xDEADBEEF, ack 1 cycle after bus_req_o -> bus_addr_o=0x40; load_valid_o pulses at T+3 with 0xDEADBEEF; stall_o high T..T+2.
- LB at 0x103 and LBU at 0x103, rdata=0x80112233 -> LB returns 0xFFFFFF80; LBU returns 0x00000080.
- LH at 0x102 and LHU at 0x102, rdata=0x8001AAAA -> LH returns 0xFFFF8001; LHU returns 0x00008001.
- SB at 0x201, rs2=0x123456AB -> wdata=0xABABABAB, wstrb=0010, bus_we_o=1; no load_valid_o.
- SH at 0x202, rs2=0x0000BEEF -> wdata=0xBEEFBEEF, wstrb=1100.
- Faults:
  - LW at 0x102 -> fault_o pulses at T+1, bus_req_o stays 0.
  - Store with funct3=011 -> fault_o pulses at T+1, bus_req_o stays 0.
  - rst_i during a 5-cycle wait -> bus_req_o drops the next cycle; a late ack produces no load_valid_o.
